// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared types and elaboration helpers for the sequential
//               arithmetic blocks (FSM state encoding, width checks).
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

  // Sequential subtractor control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // True when the operand width splits into a whole number of chunks
  function automatic bit chk_width(input int width, input int chunk);
    return (chunk > 0) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage : arith_pkg
`default_nettype wire

// File: rtl/rca.sv
`default_nettype none
// ============================================================================
// Module      : rca
// Description : Ripple-carry adder, s = a + b + cin with carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module rca #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = cin;

  // One full adder per bit, carry rippling from LSB to MSB
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[WIDTH];

endmodule : rca
`default_nettype wire

// File: rtl/seq_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : seq_subtractor
// Description : Multi-cycle subtractor, {bout, d} = a - b - bin, CHUNK bits
//               per cycle LSB first, borrow carried between cycles. Operands
//               are captured on a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNTW   = $clog2(NCHUNK) + 1;

  localparam logic [CNTW-1:0]  C_LAST = CNTW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] C_MASK = WIDTH'({CHUNK{1'b1}});

  // Reject operand widths that do not split into whole chunks
  if (!chk_width(WIDTH, CHUNK)) begin : g_bad_width
    $error("seq_subtractor: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  sub_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_acc;

  logic [31:0]      w_sh;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_diff;
  logic             w_c;
  logic             w_brw_n;
  logic [WIDTH-1:0] w_acc_next;

  // Bit offset of the chunk handled this cycle
  assign w_sh = 32'(r_cnt) * CHUNK;

  // Select the current chunk of each operand by shifting it down to bit 0
  assign w_a_sh    = r_a >> w_sh;
  assign w_b_sh    = r_b >> w_sh;
  assign w_a_chunk = w_a_sh[CHUNK-1:0];
  assign w_b_chunk = w_b_sh[CHUNK-1:0];

  // a - b - borrow computed as a + ~b + ~borrow; a missing carry means borrow
  rca #(CHUNK) u_rca (
    .a    (w_a_chunk),
    .b    (~w_b_chunk),
    .cin  (~r_borrow),
    .s    (w_diff),
    .cout (w_c)
  );

  assign w_brw_n = ~w_c;

  // Accumulator with this cycle's chunk merged in at its bit position
  assign w_acc_next = (r_acc & ~(C_MASK << w_sh)) | (WIDTH'(w_diff) << w_sh);

  // Control FSM, operand/borrow/accumulator registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      d        <= '0;
      bout     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back ops
        IDLE, DONE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        // One chunk per cycle; results are published only after the last one
        RUN: begin
          r_acc    <= w_acc_next;
          r_borrow <= w_brw_n;
          r_cnt    <= r_cnt + CNTW'(1);
          if (r_cnt == C_LAST) begin
            d       <= w_acc_next;
            bout    <= w_brw_n;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : seq_subtractor
`default_nettype wire

// File: tb/tb_seq_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_subtractor
// Description : Self-checking bench for seq_subtractor (WIDTH=8) with four
//               instances at CHUNK = 1, 2, 4, 8 sharing the same stimulus.
//               Directed cases target the CHUNK=2 instance.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_subtractor;

  localparam int W    = 8;
  localparam int MAIN = 1;  // instance index with CHUNK=2

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         bin;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         busy_v [4];
  logic         done_v [4];
  logic         bout_v [4];
  logic [W-1:0] d_v    [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    seq_subtractor #(.WIDTH(W), .CHUNK(1 << g)) u_dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (bin),
      .a     (a),
      .b     (b),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .d     (d_v[g]),
      .bout  (bout_v[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {~bout, d} is the 9-bit sum a + ~b + ~bin
  function automatic logic [W:0] golden(input logic [W-1:0] ga, input logic [W-1:0] gb,
                                        input logic gbin);
    logic [W:0] s;
    s = {1'b0, ga} + {1'b0, ~gb} + {{W{1'b0}}, ~gbin};
    return {~s[W], s[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done on the main instance, counting cycles and busy samples
  task automatic wait_done(input int limit, inout int cyc, inout int bcnt);
    while (!done_v[MAIN] && cyc < limit) begin
      tick();
      cyc++;
      if (busy_v[MAIN]) bcnt++;
    end
  endtask

  // Single operation on the main instance with hand-computed expectations
  task automatic run_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tbin, input logic [W-1:0] exp_d, input logic exp_bout);
    int cyc;
    int bcnt;
    logic [W:0] g;
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    tick();
    start = 1'b0;
    cyc  = 1;
    bcnt = busy_v[MAIN] ? 1 : 0;
    wait_done(20, cyc, bcnt);
    g = golden(ta, tb_, tbin);
    check_eq({tag, "_done"}, done_v[MAIN], 1);
    check_eq({tag, "_lat"}, cyc, 5);
    check_eq({tag, "_busy"}, bcnt, 4);
    check_eq({tag, "_d"}, d_v[MAIN], exp_d);
    check_eq({tag, "_bout"}, bout_v[MAIN], exp_bout);
    check_eq({tag, "_gold"}, {bout_v[MAIN], d_v[MAIN]}, g);
    tick();
  endtask

  initial begin
    int cyc;
    int bcnt;
    int t_first;
    int ndone;
    int nd [4];
    logic [W-1:0] last_d [4];
    logic         last_b [4];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;
    logic [W:0]   ex;

    reset = 1'b1; start = 1'b0; bin = 1'b0; a = '0; b = '0;
    #12;
    check_eq("rst_busy", busy_v[MAIN], 0);
    check_eq("rst_done", done_v[MAIN], 0);
    check_eq("rst_d", d_v[MAIN], 0);
    check_eq("rst_bout", bout_v[MAIN], 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // Basic operation and borrow cases
    run_one("basic", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    run_one("uflow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_one("bin0",  8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    run_one("binff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Back-to-back: start held, second operands captured in the DONE cycle
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    tick();
    a = 8'h80; b = 8'h7F;
    cyc = 1; bcnt = 0;
    wait_done(20, cyc, bcnt);
    check_eq("b2b_done1", done_v[MAIN], 1);
    check_eq("b2b_d1", d_v[MAIN], 8'h0F);
    t_first = cyc;
    tick();
    cyc++;
    start = 1'b0;
    wait_done(40, cyc, bcnt);
    check_eq("b2b_done2", done_v[MAIN], 1);
    check_eq("b2b_d2", d_v[MAIN], 8'h01);
    check_eq("b2b_bout2", bout_v[MAIN], 0);
    check_eq("b2b_gap", cyc - t_first, 5);
    tick();
    tick();

    // Start during RUN must be ignored
    a = 8'h20; b = 8'h10; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 8'hFF; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; bcnt = 0;
    wait_done(20, cyc, bcnt);
    check_eq("ign_done", done_v[MAIN], 1);
    check_eq("ign_d", d_v[MAIN], 8'h10);
    check_eq("ign_bout", bout_v[MAIN], 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_v[MAIN]) ndone++;
    end
    check_eq("ign_extra", ndone, 0);

    // Asynchronous reset after two chunks of an operation
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_busy", busy_v[MAIN], 0);
    check_eq("arst_done", done_v[MAIN], 0);
    check_eq("arst_d", d_v[MAIN], 0);
    check_eq("arst_bout", bout_v[MAIN], 0);
    tick();
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_v[MAIN]) ndone++;
    end
    check_eq("arst_nodone", ndone, 0);
    run_one("post", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0);

    // Random sweep across all chunk sizes, results must hold between pulses
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      last_d[k] = '0;
      last_b[k] = 1'b0;
    end
    for (int v = 0; v < 2000; v++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      ex   = golden(ra, rb, rbin);
      a = ra; b = rb; bin = rbin; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) nd[k] = 0;
      for (int c = 1; c <= 9; c++) begin
        tick();
        for (int k = 0; k < 4; k++) begin
          if (done_v[k]) begin
            nd[k]++;
            check_eq("sw_lat", c, 8 >> k);
            check_eq("sw_d", d_v[k], ex[W-1:0]);
            check_eq("sw_bout", bout_v[k], ex[W]);
            last_d[k] = d_v[k];
            last_b[k] = bout_v[k];
          end else begin
            check_eq("sw_hold", {bout_v[k], d_v[k]}, {last_b[k], last_d[k]});
          end
        end
      end
      for (int k = 0; k < 4; k++) check_eq("sw_ndone", nd[k], 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_seq_subtractor
`default_nettype wire
